// File: rtl/ofdm_cp_removal.sv
// Strips the cyclic prefix from a slot-structured OFDM sample stream and forwards
// the FFT_N useful samples of each symbol with last/symbol-index side information.
//
// state | meaning
// IDLE  | waiting for s_sof; all samples dropped
// CP    | dropping cyclic-prefix samples of symbol r_sym
// DATA  | forwarding useful samples of symbol r_sym to the output register
module ofdm_cp_removal #(
  parameter int DATA_W        = 16,
  parameter int FFT_N         = 2048,
  parameter int CP_LEN        = 144,
  parameter int CP_LEN_FIRST  = 160,
  parameter int SYMS_PER_SLOT = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_i,
  input  logic [DATA_W-1:0] s_q,
  input  logic              s_sof,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_i,
  output logic [DATA_W-1:0] m_q,
  output logic              m_last,
  output logic [3:0]        m_sym_idx,
  output logic              sync_err
);

  localparam int CNT_W = $clog2(FFT_N) + 1;
  localparam logic [CNT_W-1:0] L_FFT      = CNT_W'(FFT_N);
  localparam logic [CNT_W-1:0] L_CP       = CNT_W'(CP_LEN);
  localparam logic [CNT_W-1:0] L_CP_FIRST = CNT_W'(CP_LEN_FIRST);
  localparam logic [3:0]       L_LAST_SYM = 4'(SYMS_PER_SLOT - 1);
  localparam bit               L_CPF_ONE  = (CP_LEN_FIRST == 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CP, ST_DATA} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc, w_cp_len;
  logic [3:0]         r_sym, w_sym_nxt;
  logic               r_m_valid, r_m_last, r_sync_err;
  logic [DATA_W-1:0]  r_m_i, r_m_q;
  logic [3:0]         r_m_sym;
  logic               w_accept, w_sof_expected, w_load, w_load_last, w_resync;

  assign s_ready        = (r_state == ST_DATA) ? (!r_m_valid || m_ready) : 1'b1;
  assign w_accept       = s_valid && s_ready;
  assign w_cnt_inc      = r_cnt + 1'b1;
  assign w_cp_len       = (r_sym == 4'd0) ? L_CP_FIRST : L_CP;
  assign w_sof_expected = (r_state == ST_CP) && (r_sym == 4'd0) && (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sym_nxt   = r_sym;
    w_load      = 1'b0;
    w_load_last = 1'b0;
    w_resync    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept && s_sof) begin
          w_sym_nxt   = 4'd0;
          w_state_nxt = L_CPF_ONE ? ST_DATA : ST_CP;
          w_cnt_nxt   = L_CPF_ONE ? '0 : CNT_W'(1);
        end
      end
      ST_CP: begin
        if (w_accept) begin
          if (s_sof && !w_sof_expected) begin
            w_resync    = 1'b1;
            w_sym_nxt   = 4'd0;
            w_state_nxt = L_CPF_ONE ? ST_DATA : ST_CP;
            w_cnt_nxt   = L_CPF_ONE ? '0 : CNT_W'(1);
          end else if (w_cnt_inc == w_cp_len) begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          if (s_sof) begin
            // resync: the sof sample opens a new slot, the current symbol is cut short
            w_resync    = 1'b1;
            w_sym_nxt   = 4'd0;
            w_state_nxt = L_CPF_ONE ? ST_DATA : ST_CP;
            w_cnt_nxt   = L_CPF_ONE ? '0 : CNT_W'(1);
          end else begin
            w_load    = 1'b1;
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == L_FFT) begin
              w_load_last = 1'b1;
              w_state_nxt = ST_CP;
              w_cnt_nxt   = '0;
              w_sym_nxt   = (r_sym == L_LAST_SYM) ? 4'd0 : r_sym + 4'd1;
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sym   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sym   <= w_sym_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_i      <= '0;
      r_m_q      <= '0;
      r_m_sym    <= 4'd0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= w_resync;
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_last  <= w_load_last;
        r_m_i     <= s_i;
        r_m_q     <= s_q;
        r_m_sym   <= r_sym;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign m_i       = r_m_i;
  assign m_q       = r_m_q;
  assign m_sym_idx = r_m_sym;
  assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_ofdm_cp_removal.sv
// Self-checking bench for ofdm_cp_removal: directed vector table, corner-case
// sequences and a slot-position reference model scoring every output.
module tb_ofdm_cp_removal;
  localparam int DW   = 16;
  localparam int N    = 8;
  localparam int CPL  = 2;
  localparam int CPF  = 3;
  localparam int S    = 2;
  localparam int SLOT = CPF + N + (S - 1) * (CPL + N);

  logic          clk, rst_n;
  logic          s_valid, s_ready, s_sof;
  logic [DW-1:0] s_i, s_q;
  logic          m_valid, m_ready, m_last, sync_err;
  logic [DW-1:0] m_i, m_q;
  logic [3:0]    m_sym_idx;

  ofdm_cp_removal #(.DATA_W(DW), .FFT_N(N), .CP_LEN(CPL), .CP_LEN_FIRST(CPF),
                    .SYMS_PER_SLOT(S)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_i(s_i), .s_q(s_q), .s_sof(s_sof), .m_valid(m_valid), .m_ready(m_ready),
    .m_i(m_i), .m_q(m_q), .m_last(m_last), .m_sym_idx(m_sym_idx), .sync_err(sync_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic [DW-1:0] q;
    logic          last;
    logic [3:0]    sym;
  } out_t;

  out_t exp_q[$];
  out_t log_q[$];

  // Reference model: position within the slot decides drop / forward.
  bit            m_active = 0;
  int            m_p = 0;
  bit            err_exp = 0;
  bit            prev_hold = 0;
  logic [DW-1:0] prev_i;
  int            err_pulses = 0;

  function automatic void classify(input int p, output bit useful, output int sym, output int idx);
    int q;
    if (p < CPF + N) begin
      sym = 0;
      idx = p - CPF;
    end else begin
      q   = p - (CPF + N);
      sym = 1 + q / (CPL + N);
      idx = q % (CPL + N) - CPL;
    end
    useful = (idx >= 0);
  endfunction

  always @(negedge clk) begin
    bit   useful, err_nxt;
    int   sym, idx;
    out_t e, o;
    if (!rst_n) begin
      m_active  = 0;
      m_p       = 0;
      err_exp   = 0;
      prev_hold = 0;
      exp_q.delete();
    end else begin
      chk("sync_err", sync_err, err_exp);
      if (sync_err) err_pulses++;
      if (prev_hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_i, prev_i);
      end
      if (m_valid && m_ready) begin
        o.d = m_i; o.q = m_q; o.last = m_last; o.sym = m_sym_idx;
        log_q.push_back(o);
        chk("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_i", m_i, e.d);
          chk("out_q", m_q, e.q);
          chk("out_last", m_last, e.last);
          chk("out_sym", m_sym_idx, e.sym);
        end
      end
      err_nxt = 0;
      if (s_valid && s_ready) begin
        if (s_sof) begin
          if (m_active && m_p != 0) err_nxt = 1;
          m_active = 1;
          m_p      = 0;
        end
        if (m_active) begin
          classify(m_p, useful, sym, idx);
          if (useful) begin
            e.d = s_i; e.q = s_q; e.last = (idx == N - 1); e.sym = 4'(sym);
            exp_q.push_back(e);
          end
          m_p = (m_p + 1) % SLOT;
        end
      end
      err_exp   = err_nxt;
      prev_hold = m_valid && !m_ready;
      prev_i    = m_i;
    end
  end

  task automatic drive(input logic v, input logic sof, input logic [DW-1:0] d,
                       input logic mr, output logic acc);
    s_valid = v;
    s_sof   = sof;
    s_i     = d;
    s_q     = ~d;
    m_ready = mr;
    #1;
    acc = v && s_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic          sof;
    logic [DW-1:0] d;
    logic          exp_v;
    logic          exp_last;
    logic [3:0]    exp_sym;
  } vec_t;

  vec_t tbl[22];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   n;
    int   exp_list[$];

    rst_n = 1'b0; s_valid = 0; s_sof = 0; s_i = '0; s_q = '0; m_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_i", m_i, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_sym", m_sym_idx, 0);
    chk("rst_sync_err", sync_err, 0);
    rst_n = 1'b1;

    // Continuous slot with m_ready high: useful samples 3..10 and 13..20.
    for (int k = 0; k < 22; k++) begin
      tbl[k].sof      = (k == 0);
      tbl[k].d        = 16'(k);
      tbl[k].exp_v    = (k >= 3 && k <= 10) || (k >= 13 && k <= 20);
      tbl[k].exp_last = (k == 10) || (k == 20);
      tbl[k].exp_sym  = (k >= 13) ? 4'd1 : 4'd0;
    end
    for (int k = 0; k < 22; k++) begin
      drive(1, tbl[k].sof, tbl[k].d, 1, acc);
      chk("tbl_accept", acc, 1);
      chk("tbl_valid", m_valid, tbl[k].exp_v);
      if (tbl[k].exp_v) begin
        chk("tbl_data", m_i, tbl[k].d);
        chk("tbl_last", m_last, tbl[k].exp_last);
        chk("tbl_sym", m_sym_idx, tbl[k].exp_sym);
      end
      chk("tbl_sync_err", sync_err, 0);
    end
    repeat (2) drive(0, 0, '0, 1, acc);
    chk("tbl_idle_valid", m_valid, 0);

    // Samples before sof are dropped; first output is sof sample + 3.
    do_reset();
    for (int j = 0; j < 5; j++) begin
      drive(1, 0, 16'(200 + j), 1, acc);
      chk("pre_sof_valid", m_valid, 0);
    end
    log_q.delete();
    for (int j = 0; j < 16; j++) drive(1, j == 0, 16'(300 + j), 1, acc);
    chk("first_out_count", log_q.size(), 10);
    if (log_q.size() > 0) chk("first_out_data", log_q[0].d, 303);

    // Backpressure for 4 cycles during symbol 1 data.
    for (int j = 0; j < 4; j++) begin
      drive(1, 0, 16'd316, 0, acc);
      chk("stall_s_ready", acc, 0);
      chk("stall_m_valid", m_valid, 1);
      chk("stall_m_i", m_i, 315);
    end
    log_q.delete();
    for (int j = 0; j < 5; j++) begin
      drive(1, 0, 16'(316 + j), 1, acc);
      chk("resume_accept", acc, 1);
    end
    repeat (2) drive(0, 0, '0, 1, acc);
    chk("stall_out_count", log_q.size(), 6);
    for (int j = 0; j < 6 && j < log_q.size(); j++) begin
      chk("stall_order", log_q[j].d, 315 + j);
      chk("stall_last", log_q[j].last, j == 5);
      chk("stall_sym", log_q[j].sym, 1);
    end

    // Unexpected sof on 5th useful sample of symbol 1, then async reset mid-symbol.
    do_reset();
    log_q.delete();
    err_pulses = 0;
    for (int j = 0; j < 33; j++) begin
      drive(1, (j == 0) || (j == 17), 16'(j), 1, acc);
      chk("resync_sync_err", sync_err, j == 17);
    end
    chk("resync_pulses", err_pulses, 1);
    chk("pre_rst_valid", m_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", m_valid, 0);
    chk("async_rst_ready", s_ready, 1);
    chk("async_rst_m_i", m_i, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_list = {3, 4, 5, 6, 7, 8, 9, 10, 13, 14, 15, 16, 20, 21, 22, 23, 24, 25, 26, 27, 30, 31};
    chk("resync_out_count", log_q.size(), exp_list.size());
    for (int j = 0; j < exp_list.size() && j < log_q.size(); j++) begin
      chk("resync_data", log_q[j].d, exp_list[j]);
      chk("resync_last", log_q[j].last, (exp_list[j] == 10) || (exp_list[j] == 27));
      chk("resync_sym", log_q[j].sym,
          ((exp_list[j] >= 13 && exp_list[j] <= 16) || exp_list[j] >= 30) ? 1 : 0);
    end
    log_q.delete();
    for (int j = 0; j < 10; j++) begin
      drive(1, 0, 16'(500 + j), 1, acc);
      chk("post_rst_valid", m_valid, 0);
    end
    chk("post_rst_outputs", log_q.size(), 0);

    // Random valid/ready over 10 slots, scored by the reference model.
    log_q.delete();
    n = 0;
    for (int it = 0; it < 4000 && n < 10 * SLOT; it++) begin
      drive($urandom_range(0, 3) != 0, (n % SLOT) == 0, 16'(1000 + n),
            $urandom_range(0, 2) != 0, acc);
      if (acc) n++;
    end
    chk("rand_all_accepted", n, 10 * SLOT);
    for (int it = 0; it < 20 && (exp_q.size() > 0 || m_valid); it++) drive(0, 0, '0, 1, acc);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_out_count", log_q.size(), 10 * S * N);
    for (int j = 0; j < log_q.size(); j++) chk("rand_last_every_8", log_q[j].last, (j % N) == N - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofdm_cp_removal.md
OFDM_CP_REMOVAL -- requirements
Module: ofdm_cp_removal

Interface
REQ-001 SHALL have parameter DATA_W, default 16: bit width of each I and Q sample component, two's complement.
REQ-002 SHALL have parameter FFT_N, default 2048: useful samples per OFDM symbol; power of two, 8 to 4096.
REQ-003 SHALL have parameter CP_LEN, default 144: cyclic-prefix length of symbols 1..SYMS_PER_SLOT-1; 1 to FFT_N-1.
REQ-004 SHALL have parameter CP_LEN_FIRST, default 160: cyclic-prefix length of symbol 0 of each slot; 1 to FFT_N-1.
REQ-005 SHALL have parameter SYMS_PER_SLOT, default 7: symbols per slot; 1 to 14.
REQ-006 SHALL have ports, clock and reset first:
 clk  input  1  single clock; all logic on rising edge
 rst_n  input  1  asynchronous active-low reset; deassertion synchronous to clk externally
 s_valid  input  1  input sample valid
 s_ready  output  1  input sample accepted when s_valid && s_ready
 s_i, s_q  input  DATA_W each  input time-domain sample
 s_sof  input  1  qualified by s_valid; marks the first CP sample of symbol 0 of a slot
 m_valid  output  1  output sample valid
 m_ready  input  1  downstream (FFT) ready
 m_i, m_q  output  DATA_W each  forwarded useful sample
 m_last  output  1  with m_valid: last (FFT_N-th) sample of a symbol
 m_sym_idx  output  4  symbol index within slot, 0..SYMS_PER_SLOT-1, constant across a symbol
 sync_err  output  1  one-cycle pulse on s_sof at an unexpected position

Function
REQ-007 SHALL implement states IDLE, CP, DATA; accepted input sample = s_valid && s_ready.
REQ-008 IDLE: s_ready=1; accepted samples without s_sof dropped; accepted sample with s_sof counted as CP sample 1 of symbol 0 -> CP (sym_idx=0, cnt=1).
REQ-009 CP: s_ready=1; every accepted sample dropped, cnt incremented; on accepting CP sample number cp_len (CP_LEN_FIRST if sym_idx==0 else CP_LEN) -> DATA, cnt=0.
REQ-010 DATA: s_ready = !m_valid || m_ready; each accepted sample loaded into the output register with m_valid=1, cnt incremented; sample FFT_N loaded with m_last=1 -> CP, cnt=0, sym_idx = (sym_idx+1) mod SYMS_PER_SLOT.
REQ-011 Output register SHALL hold m_i/m_q/m_last/m_sym_idx stable while m_valid && !m_ready; m_valid cleared when m_ready=1 and no new sample loaded that cycle.
REQ-012 Latency SHALL be exactly one cycle from acceptance to m_valid; full throughput (one sample/cycle) when m_ready held high.
REQ-013 Expected-sof position = first accepted sample in CP with sym_idx==0 and cnt==0; s_sof there is normal.
REQ-014 s_sof on any other accepted sample in CP or DATA SHALL pulse sync_err for one cycle (cycle after acceptance) and resynchronise: sample becomes CP sample 1 of symbol 0; any symbol in progress is truncated (m_last not generated for it); the output register still drains its held sample.
REQ-015 Missing s_sof at the expected position SHALL not be an error; block free-runs on its counters.
REQ-016 Samples SHALL pass unmodified (no arithmetic); cnt width clog2(FFT_N)+1, wrap never occurs beyond FFT_N.
REQ-017 If CP_LEN_FIRST reached and s_valid low, state SHALL not advance without an accepted sample; bubbles on s_valid stall counters only.

Reset
REQ-018 On rst_n low, asynchronously: state=IDLE, cnt=0, sym_idx=0, m_valid=0, m_last=0, m_i=m_q=0, m_sym_idx=0, sync_err=0; s_ready=1 (IDLE).
REQ-019 Reset mid-symbol SHALL discard held output and partial symbol; after release, only s_sof restarts forwarding.

Verification (FFT_N=8, CP_LEN=2, CP_LEN_FIRST=3, SYMS_PER_SLOT=2, DATA_W=16)
REQ-020 Continuous samples 0..21 with s_sof on sample 0, m_ready=1 -> outputs 3..10 (sym 0, m_last on 10), then 13..20 (sym 1, m_last on 20); sample 21 dropped as symbol-0 CP; no sync_err.
REQ-021 Samples before s_sof -> no m_valid; first output is sof sample index +3.
REQ-022 m_ready low for 4 cycles during DATA -> s_ready low, held m_i unchanged, no sample lost or duplicated, order preserved.
REQ-023 s_sof re-asserted on 5th useful sample of symbol 1 -> sync_err pulse 1 cycle, no m_last for that symbol, next 3 samples dropped, following 8 forwarded with m_sym_idx=0.
REQ-024 rst_n asserted with m_valid=1 mid-symbol -> m_valid=0 same cycle asynchronously; post-reset samples ignored until s_sof.
REQ-025 Random s_valid/m_ready toggling over 10 slots -> output stream equals reference model of CP-stripped input, m_last every 8th output.
